// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage issue/hazard signals between pipeline control and the scoreboard
interface hazard_scoreboard_if #(parameter int PERF_W = 32);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [4:0]        id_rd;
    logic              id_regWrite;
    logic              ex_branch_taken;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              issue;
    logic              stall;
    logic              bubble;
    logic              flush_ifid;
    logic              sb_err;
    logic [PERF_W-1:0] stall_cycles;
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regWrite,
               ex_branch_taken, wb_valid, wb_rd,
        input  issue, stall, bubble, flush_ifid, sb_err, stall_cycles
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regWrite,
               ex_branch_taken, wb_valid, wb_rd,
        output issue, stall, bubble, flush_ifid, sb_err, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters deciding issue/stall/bubble/flush for IF/ID
module hazard_scoreboard #(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] MAXP = '1;
    logic [CNT_W-1:0] pend [1:31];
    logic busy1, busy2, raw_hazard, waw_full, blocked, inc, dec, dec_err;
    assign busy1      = sb.id_rs1 != 5'd0 && pend[sb.id_rs1] != '0;
    assign busy2      = sb.id_rs2 != 5'd0 && pend[sb.id_rs2] != '0;
    assign raw_hazard = (sb.id_use_rs1 && busy1) || (sb.id_use_rs2 && busy2);
    assign waw_full   = sb.id_regWrite && sb.id_rd != 5'd0 && pend[sb.id_rd] == MAXP;
    assign blocked    = raw_hazard || waw_full;
    assign sb.flush_ifid = sb.ex_branch_taken;
    assign sb.stall      = !sb.ex_branch_taken && sb.id_valid && blocked;
    assign sb.issue      = !sb.ex_branch_taken && sb.id_valid && !blocked;
    assign sb.bubble     = !sb.issue;
    assign inc     = sb.issue && sb.id_regWrite && sb.id_rd != 5'd0;
    assign dec     = sb.wb_valid && sb.wb_rd != 5'd0 && pend[sb.wb_rd] != '0;
    assign dec_err = sb.wb_valid && sb.wb_rd != 5'd0 && pend[sb.wb_rd] == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) pend[i] <= '0;
            sb.sb_err       <= 1'b0;
            sb.stall_cycles <= '0;
        end else begin
            // coincident inc and dec on the same register cancel out
            for (int i = 1; i < 32; i++) begin
                if (inc && sb.id_rd == 5'(i) && !(dec && sb.wb_rd == 5'(i)))
                    pend[i] <= pend[i] + CNT_W'(1);
                else if (dec && sb.wb_rd == 5'(i) && !(inc && sb.id_rd == 5'(i)))
                    pend[i] <= pend[i] - CNT_W'(1);
            end
            sb.sb_err       <= sb.sb_err | dec_err;
            sb.stall_cycles <= sb.stall_cycles + PERF_W'(sb.stall && !(&sb.stall_cycles));
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table-driven directed checks of the hazard scoreboard plus a RAW latency sequence
module tb_hazard_scoreboard;
    typedef struct {
        bit       chk;
        bit       r;
        bit       v;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
        bit [4:0] rd;
        bit       rw;
        bit       br;
        bit       wbv;
        bit [4:0] wbrd;
        bit       ei;
        bit       es;
        bit       eb;
        bit       ef;
        bit       ee;
        int       sc;
    } vec_t;

    logic clk = 0;
    logic rst;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    hazard_scoreboard_if #(.PERF_W(32)) bus ();
    hazard_scoreboard #(.CNT_W(2), .PERF_W(32)) dut (.clk(clk), .rst(rst), .sb(bus));

    always #5 clk = ~clk;

    function automatic vec_t mk(bit chk, bit r, bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                                bit [4:0] rd, bit rw, bit br, bit wbv, bit [4:0] wbrd,
                                bit ei, bit es, bit eb, bit ef, bit ee, int sc);
        vec_t t;
        t.chk = chk; t.r = r; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.rw = rw; t.br = br; t.wbv = wbv; t.wbrd = wbrd;
        t.ei = ei; t.es = es; t.eb = eb; t.ef = ef; t.ee = ee; t.sc = sc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.r;
        bus.id_valid = t.v; bus.id_rs1 = t.rs1; bus.id_use_rs1 = t.u1;
        bus.id_rs2 = t.rs2; bus.id_use_rs2 = t.u2; bus.id_rd = t.rd; bus.id_regWrite = t.rw;
        bus.ex_branch_taken = t.br; bus.wb_valid = t.wbv; bus.wb_rd = t.wbrd;
    endtask

    initial begin
        int n;
        bit got;
        //          chk r v rs1 u1 rs2 u2 rd rw br wbv wbrd  ei es eb ef ee sc
        tbl.push_back(mk(0,1,1, 3,1, 0,0, 4,1,0,1, 6, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,0,0));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 5,1,0,0, 0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,1, 5,1, 0,0, 0,0,0,0, 0, 0,1,1,0,0,0));
        tbl.push_back(mk(1,0,1, 5,1, 0,0, 0,0,0,0, 0, 0,1,1,0,0,1));
        tbl.push_back(mk(1,0,1, 5,1, 0,0, 0,0,0,1, 5, 0,1,1,0,0,2));
        tbl.push_back(mk(1,0,1, 5,1, 0,0, 0,0,0,0, 0, 1,0,0,0,0,3));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,0,3));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 0,1,0,0, 0, 1,0,0,0,0,3));
        tbl.push_back(mk(1,0,1, 0,1, 0,1, 0,0,0,0, 0, 1,0,0,0,0,3));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,1, 0, 0,0,1,0,0,3));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,0,3));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,0,1, 0,0, 0,0, 7,1,0,0, 0, 1,0,0,0,0,3));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 7,1,0,0, 0, 0,1,1,0,0,3));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 7,1,0,1, 7, 0,1,1,0,0,4));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 7,1,0,0, 0, 1,0,0,0,0,5));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 7,1,0,0, 0, 0,1,1,0,0,5));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,0,6));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 9,1,0,0, 0, 1,0,0,0,0,6));
        tbl.push_back(mk(1,0,1, 0,0, 0,0, 9,1,0,1, 9, 1,0,0,0,0,6));
        tbl.push_back(mk(1,0,1, 9,1, 0,0, 0,0,0,1, 9, 0,1,1,0,0,6));
        tbl.push_back(mk(1,0,1, 9,1, 0,0, 0,0,0,0, 0, 1,0,0,0,0,7));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,1,12, 0,0,1,0,0,7));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,1,7));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,1,7));
        tbl.push_back(mk(1,0,1, 7,1, 0,0,13,1,1,0, 0, 0,0,1,1,1,7));
        tbl.push_back(mk(1,0,1,13,1, 0,0, 0,0,0,0, 0, 1,0,0,0,1,7));
        tbl.push_back(mk(1,0,1, 0,0, 7,1, 0,0,0,0, 0, 0,1,1,0,1,7));
        tbl.push_back(mk(1,0,0, 0,0, 0,0, 0,0,0,0, 0, 0,0,1,0,1,8));
        tbl.push_back(mk(1,1,1, 7,1, 0,0, 0,0,0,0, 0, 0,1,1,0,1,8));
        tbl.push_back(mk(1,0,1, 7,1, 0,0, 0,0,0,0, 0, 1,0,0,0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_issue", i), 32'(bus.issue), 32'(tbl[i].ei));
                chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tbl[i].es));
                chk($sformatf("v%0d_bubble", i), 32'(bus.bubble), 32'(tbl[i].eb));
                chk($sformatf("v%0d_flush", i), 32'(bus.flush_ifid), 32'(tbl[i].ef));
                chk($sformatf("v%0d_sb_err", i), 32'(bus.sb_err), 32'(tbl[i].ee));
                chk($sformatf("v%0d_stall_cycles", i), bus.stall_cycles, tbl[i].sc);
            end
        end

        // producer to rd=20, consumer waits until the cycle after its writeback
        @(negedge clk);
        drive(mk(0,0,1, 0,0, 0,0,20,1,0,0, 0, 0,0,0,0,0,0));
        #1 chk("seq_producer_issue", 32'(bus.issue), 32'd1);
        @(negedge clk);
        drive(mk(0,0,1,20,1, 0,0, 0,0,0,0,20, 0,0,0,0,0,0));
        n = 0;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            bus.wb_valid = (k == 2);
            #1;
            if (bus.issue) got = 1;
            else n++;
            @(negedge clk);
            bus.id_valid = !got;
        end
        chk("seq_consumer_issued", 32'(got), 32'd1);
        chk("seq_stall_count", 32'(n), 32'd3);
        bus.wb_valid = 0;
        #1 chk("seq_stall_cycles", bus.stall_cycles, 32'd3);
        chk("seq_sb_err", 32'(bus.sb_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
